// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU trace checker.
package cpu_trace_pkg;

  // Parser states; StDone lasts one cycle and then behaves like StIdle.
  typedef enum logic [3:0] {
    StIdle,
    StTime,
    StPc,
    StColon,
    StSp1,
    StGrf,
    StAddr,
    StSp2,
    StLt,
    StSp3,
    StData,
    StDone
  } state_e;

  // format_type encodings
  localparam logic [1:0] FMT_NONE = 2'd0;
  localparam logic [1:0] FMT_GRF  = 2'd1;
  localparam logic [1:0] FMT_MEM  = 2'd2;

  // error_code bit positions
  localparam int unsigned ERR_TIME = 0;
  localparam int unsigned ERR_PC   = 1;
  localparam int unsigned ERR_ADDR = 2;
  localparam int unsigned ERR_GRF  = 3;

  // ASCII characters used by the grammar
  localparam logic [7:0] CH_CARET  = 8'h5e;  // ^
  localparam logic [7:0] CH_AT     = 8'h40;  // @
  localparam logic [7:0] CH_COLON  = 8'h3a;  // :
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;  // $
  localparam logic [7:0] CH_STAR   = 8'h2a;  // *
  localparam logic [7:0] CH_LT     = 8'h3c;  // <
  localparam logic [7:0] CH_EQ     = 8'h3d;  // =
  localparam logic [7:0] CH_HASH   = 8'h23;  // #
  localparam logic [7:0] CH_0      = 8'h30;
  localparam logic [7:0] CH_9      = 8'h39;
  localparam logic [7:0] CH_A_LC   = 8'h61;
  localparam logic [7:0] CH_F_LC   = 8'h66;

endpackage

// File: rtl/trace_char_class.sv
// Combinational character classifier: decimal / lowercase hex / space, plus nibble value.
module trace_char_class
  import cpu_trace_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_is_dec,
  output logic       o_is_hex,
  output logic       o_is_space,
  output logic [3:0] o_nibble
);

  logic w_is_af;

  // Classify the character and derive its hex digit value.
  always_comb begin
    o_is_dec   = (i_char >= CH_0) && (i_char <= CH_9);
    w_is_af    = (i_char >= CH_A_LC) && (i_char <= CH_F_LC);
    o_is_hex   = o_is_dec || w_is_af;
    o_is_space = (i_char == CH_SPACE);
    o_nibble   = 4'h0;
    if (o_is_dec) begin
      o_nibble = i_char[3:0];
    end else if (w_is_af) begin
      // 'a'..'f' are 0x61..0x66, so low nibble + 9 gives 10..15
      o_nibble = i_char[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/cpu_trace_checker.sv
// CPU trace line parser: classifies register/memory write records, flags semantic errors
// and keeps saturating line/error statistics.
module cpu_trace_checker
  import cpu_trace_pkg::*;
#(
  parameter int unsigned TIME_DIGITS = 4,
  parameter int unsigned GRF_DIGITS  = 4,
  parameter int unsigned NUM_GRF     = 32,
  parameter logic [31:0] PC_LO       = 32'h0000_3000,
  parameter logic [31:0] PC_HI       = 32'h0000_4fff,
  parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
  parameter int unsigned FREQ_W      = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        char,
  input  logic [FREQ_W-1:0] freq,
  output logic [1:0]        format_type,
  output logic [3:0]        error_code,
  output logic [CNT_W-1:0]  line_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned TW      = 4 * TIME_DIGITS;
  localparam int unsigned GW      = 4 * GRF_DIGITS;
  localparam int unsigned MW      = (TW > FREQ_W) ? TW : FREQ_W;
  localparam int unsigned CW      = GW + 32;
  localparam int unsigned MAX_DIG = (TIME_DIGITS > GRF_DIGITS) ?
                                    ((TIME_DIGITS > 8) ? TIME_DIGITS : 8) :
                                    ((GRF_DIGITS > 8) ? GRF_DIGITS : 8);
  localparam int unsigned DIG_W   = $clog2(MAX_DIG + 1);

  localparam logic [DIG_W-1:0] TIME_MAX = DIG_W'(TIME_DIGITS);
  localparam logic [DIG_W-1:0] GRF_MAX  = DIG_W'(GRF_DIGITS);
  localparam logic [DIG_W-1:0] HEX_LAST = DIG_W'(7);
  localparam logic [DIG_W-1:0] HEX_FULL = DIG_W'(8);

  state_e           r_state, w_state_d;
  logic [DIG_W-1:0] r_dig, w_dig_d;
  logic [TW-1:0]    r_time, w_time_d;
  logic [GW-1:0]    r_grf, w_grf_d;
  logic [31:0]      r_pc, w_pc_d;
  logic [31:0]      r_addr, w_addr_d;
  logic             r_is_mem, w_is_mem_d;
  logic             w_done;

  logic [1:0]       r_format;
  logic [3:0]       r_error;
  logic [CNT_W-1:0] r_line_cnt, r_err_cnt;

  logic             w_is_dec, w_is_hex, w_is_space;
  logic [3:0]       w_nibble;
  logic [MW-1:0]    w_half, w_time_mod;
  logic [3:0]       w_err;

  trace_char_class u_class (
    .i_char     (char),
    .o_is_dec   (w_is_dec),
    .o_is_hex   (w_is_hex),
    .o_is_space (w_is_space),
    .o_nibble   (w_nibble)
  );

  // Parser state and accumulator registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_dig    <= '0;
      r_time   <= '0;
      r_grf    <= '0;
      r_pc     <= '0;
      r_addr   <= '0;
      r_is_mem <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_dig    <= w_dig_d;
      r_time   <= w_time_d;
      r_grf    <= w_grf_d;
      r_pc     <= w_pc_d;
      r_addr   <= w_addr_d;
      r_is_mem <= w_is_mem_d;
    end
  end

  // Next-state and accumulator update; data digits are only counted because their value
  // never reaches an output.
  always_comb begin
    w_state_d  = r_state;
    w_dig_d    = r_dig;
    w_time_d   = r_time;
    w_grf_d    = r_grf;
    w_pc_d     = r_pc;
    w_addr_d   = r_addr;
    w_is_mem_d = r_is_mem;
    w_done     = 1'b0;
    if (char == CH_CARET) begin
      // Resynchronise from any state
      w_state_d  = StTime;
      w_dig_d    = '0;
      w_time_d   = '0;
      w_grf_d    = '0;
      w_pc_d     = '0;
      w_addr_d   = '0;
      w_is_mem_d = 1'b0;
    end else begin
      w_state_d = StIdle;
      unique case (r_state)
        StTime: begin
          if (w_is_dec && (r_dig < TIME_MAX)) begin
            w_state_d = StTime;
            w_time_d  = TW'(r_time * TW'(10)) + TW'(w_nibble);
            w_dig_d   = r_dig + 1'b1;
          end else if ((char == CH_AT) && (r_dig != '0)) begin
            w_state_d = StPc;
            w_dig_d   = '0;
          end
        end
        StPc: begin
          if (w_is_hex) begin
            w_pc_d    = {r_pc[27:0], w_nibble};
            w_dig_d   = r_dig + 1'b1;
            w_state_d = (r_dig == HEX_LAST) ? StColon : StPc;
          end
        end
        StColon: begin
          if (char == CH_COLON) w_state_d = StSp1;
        end
        StSp1: begin
          if (w_is_space) begin
            w_state_d = StSp1;
          end else if (char == CH_DOLLAR) begin
            w_state_d  = StGrf;
            w_dig_d    = '0;
            w_is_mem_d = 1'b0;
          end else if (char == CH_STAR) begin
            w_state_d  = StAddr;
            w_dig_d    = '0;
            w_is_mem_d = 1'b1;
          end
        end
        StGrf: begin
          if (w_is_dec && (r_dig < GRF_MAX)) begin
            w_state_d = StGrf;
            w_grf_d   = GW'(r_grf * GW'(10)) + GW'(w_nibble);
            w_dig_d   = r_dig + 1'b1;
          end else if (w_is_space && (r_dig != '0)) begin
            w_state_d = StSp2;
          end else if ((char == CH_LT) && (r_dig != '0)) begin
            w_state_d = StLt;
          end
        end
        StAddr: begin
          if (w_is_hex) begin
            w_addr_d  = {r_addr[27:0], w_nibble};
            w_dig_d   = r_dig + 1'b1;
            w_state_d = (r_dig == HEX_LAST) ? StSp2 : StAddr;
          end
        end
        StSp2: begin
          if (w_is_space)         w_state_d = StSp2;
          else if (char == CH_LT) w_state_d = StLt;
        end
        StLt: begin
          if (char == CH_EQ) w_state_d = StSp3;
        end
        StSp3: begin
          if (w_is_space) begin
            w_state_d = StSp3;
          end else if (w_is_hex) begin
            w_state_d = StData;
            w_dig_d   = DIG_W'(1);
          end
        end
        StData: begin
          if (w_is_hex && (r_dig < HEX_FULL)) begin
            w_state_d = StData;
            w_dig_d   = r_dig + 1'b1;
          end else if ((char == CH_HASH) && (r_dig == HEX_FULL)) begin
            w_state_d = StDone;
            w_done    = 1'b1;
          end
        end
        default: w_state_d = StIdle;  // StIdle, StDone: wait for '^'
      endcase
    end
  end

  // Semantic checks on the values accumulated when '#' arrives.
  always_comb begin
    w_half     = MW'(freq >> 1);
    w_time_mod = (w_half != '0) ? (MW'(r_time) % w_half) : '0;
    w_err      = '0;
    w_err[ERR_TIME] = (w_time_mod != '0);
    w_err[ERR_PC]   = (r_pc < PC_LO) || (r_pc > PC_HI) || (r_pc[1:0] != 2'b00);
    w_err[ERR_ADDR] = r_is_mem && ((r_addr > ADDR_HI) || (r_addr[1:0] != 2'b00));
    w_err[ERR_GRF]  = !r_is_mem && (CW'(r_grf) >= CW'(NUM_GRF));
  end

  // One-cycle report registers and saturating statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_format   <= FMT_NONE;
      r_error    <= '0;
      r_line_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_done) begin
      r_format <= r_is_mem ? FMT_MEM : FMT_GRF;
      r_error  <= w_err;
      if (r_line_cnt != '1) r_line_cnt <= r_line_cnt + 1'b1;
      if ((w_err != '0) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
    end else begin
      r_format <= FMT_NONE;
      r_error  <= '0;
    end
  end

  assign format_type = r_format;
  assign error_code  = r_error;
  assign line_cnt    = r_line_cnt;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Self-checking bench for cpu_trace_checker: table of trace lines with a scoreboard of
// expected reports, plus hand-written reset and counter-saturation sequences.
module tb_cpu_trace_checker;
  import cpu_trace_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ch, ch2;
  logic [15:0] freq;
  logic [1:0]  fmt, fmt2;
  logic [3:0]  ec, ec2;
  logic [15:0] lc, erc;
  logic [1:0]  lc2, erc2;

  always #5 clk = ~clk;

  cpu_trace_checker u_dut (
    .clk         (clk),
    .reset       (reset),
    .char        (ch),
    .freq        (freq),
    .format_type (fmt),
    .error_code  (ec),
    .line_cnt    (lc),
    .err_cnt     (erc)
  );

  cpu_trace_checker #(.CNT_W(2)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .char        (ch2),
    .freq        (freq),
    .format_type (fmt2),
    .error_code  (ec2),
    .line_cnt    (lc2),
    .err_cnt     (erc2)
  );

  typedef struct {
    string       line;
    logic [15:0] freq;
    logic [1:0]  fmt;
    logic [3:0]  err;
  } vec_t;

  typedef struct {
    logic [1:0] fmt;
    logic [3:0] err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_line = 0, exp_err = 0, exp_line2 = 0, exp_err2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic add_vec(input string s, input logic [15:0] f, input logic [1:0] fm,
                         input logic [3:0] e);
    vec_t v;
    v.line = s; v.freq = f; v.fmt = fm; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic send_char(input logic [7:0] c, input bit sel);
    @(negedge clk);
    if (sel) ch2 = c;
    else     ch  = c;
    @(posedge clk);
    #1;
  endtask

  // Drive a line ending in '#'; the expected report is queued when '#' is driven and
  // compared one edge later. All earlier characters must leave the outputs at zero.
  task automatic send_line(input string s, input bit sel, input logic [1:0] efmt,
                           input logic [3:0] eerr);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      if (i == s.len() - 1) begin
        e.fmt = efmt; e.err = eerr;
        sb.push_back(e);
      end
      send_char(s[i], sel);
      if (i != s.len() - 1) begin
        check("idle_out", sel ? {26'd0, fmt2, ec2} : {26'd0, fmt, ec}, 32'd0);
      end else if (sb.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.fmt != FMT_NONE) begin
          if (sel) begin
            if (exp_line2 < 3) exp_line2++;
            if (e.err != 0 && exp_err2 < 3) exp_err2++;
          end else begin
            exp_line++;
            if (e.err != 0) exp_err++;
          end
        end
        if (sel) begin
          check("format_type2", {30'd0, fmt2}, {30'd0, e.fmt});
          check("error_code2", {28'd0, ec2}, {28'd0, e.err});
          check("line_cnt2", {30'd0, lc2}, exp_line2);
          check("err_cnt2", {30'd0, erc2}, exp_err2);
        end else begin
          check("format_type", {30'd0, fmt}, {30'd0, e.fmt});
          check("error_code", {28'd0, ec}, {28'd0, e.err});
          check("line_cnt", {16'd0, lc}, exp_line);
          check("err_cnt", {16'd0, erc}, exp_err);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ch    = " ";
    ch2   = " ";
    freq  = 16'd8;

    add_vec("^124@000030fc: $9 <= 89abcdef#",       16'd8, 2'd1, 4'b0000);
    add_vec("^123@00003002:*00002ffd<=00000000#",    16'd8, 2'd2, 4'b0111);
    add_vec("^12@00005000:   $32 <= 00000001#",      16'd8, 2'd1, 4'b1010);
    add_vec("^12345@00003000: $1 <= 00000001#",      16'd8, 2'd0, 4'b0000);
    add_vec("^1@0000^8@00003000: $0 <= 0000000a#",   16'd8, 2'd1, 4'b0000);
    add_vec("^8@00003004:*00000010 <=  12345678#",   16'd8, 2'd2, 4'b0000);
    add_vec("^9996@00004ffc:$31<=ffffffff#",         16'd8, 2'd1, 4'b0000);
    add_vec("^8@00003000: $1 <= 0000001#",           16'd8, 2'd0, 4'b0000);
    add_vec("^8@00003000: $00001 <= 00000001#",      16'd8, 2'd0, 4'b0000);
    add_vec("^8@00003000: $1 <= 0000000A#",          16'd8, 2'd0, 4'b0000);
    add_vec("^10@00002ffc:*00003000<=00000000#",     16'd6, 2'd2, 4'b0111);
    add_vec("^9@00004ffd:$7<=00000000#",             16'd6, 2'd1, 4'b0010);
    add_vec("^8@0000300:$1<=00000001#",              16'd8, 2'd0, 4'b0000);
    add_vec("^@00003000:$1<=00000001#",              16'd8, 2'd0, 4'b0000);
    add_vec("^4@00003000:*00002ffc<=00000001#",      16'd2, 2'd2, 4'b0000);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_format", {30'd0, fmt}, 32'd0);
    check("rst_error", {28'd0, ec}, 32'd0);
    check("rst_line_cnt", {16'd0, lc}, 32'd0);
    check("rst_err_cnt", {16'd0, erc}, 32'd0);

    // Lines are sent back to back, so each '^' follows DONE directly
    foreach (vecs[i]) begin
      freq = vecs[i].freq;
      send_line(vecs[i].line, 1'b0, vecs[i].fmt, vecs[i].err);
    end
    freq = 16'd8;
    send_char(" ", 1'b0);
    check("after_done", {26'd0, fmt, ec}, 32'd0);

    // Reset asserted between edges mid-line: clears at once, and the tail reports nothing
    for (int i = 0; i < 18; i++) begin
      string s;
      s = "^16@00003000: $3 <";
      send_char(s[i], 1'b0);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_format", {30'd0, fmt}, 32'd0);
    check("async_line_cnt", {16'd0, lc}, 32'd0);
    check("async_err_cnt", {16'd0, erc}, 32'd0);
    #1 reset = 1'b0;
    exp_line = 0;
    exp_err  = 0;
    send_line("= 00000005#", 1'b0, 2'd0, 4'b0000);
    send_line("^16@00003000: $3 <= 00000005#", 1'b0, 2'd1, 4'b0000);

    // Two-bit counters saturate at 3
    for (int n = 0; n < 5; n++) begin
      send_line("^8@00005000:$1<=00000000#", 1'b1, 2'd1, 4'b0010);
    end
    check("sat_line_cnt", {30'd0, lc2}, 32'd3);
    check("sat_err_cnt", {30'd0, erc2}, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
